// File: rtl/sram_wide_rd_if.sv
// Valid/ready bundle for sram_wide_rd: one narrow write channel and one packed
// read channel (request address in, DATA_WIDTH_O word out).
interface sram_wide_rd_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_ENTRIES    = 1024,
  parameter int DATA_WIDTH_O = 64
);
  localparam int AW = $clog2(N_ENTRIES);

  logic                      wr_valid_i;
  logic                      wr_ready_o;
  logic [AW-1:0]             wr_addr_i;
  logic [DATA_WIDTH-1:0]     wr_data_i;
  logic [DATA_WIDTH/8-1:0]   wr_strb_i;

  logic                      rd_req_valid_i;
  logic                      rd_req_ready_o;
  logic [AW-1:0]             rd_addr_i;
  logic                      rd_valid_o;
  logic                      rd_ready_i;
  logic [DATA_WIDTH_O-1:0]   rd_data_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i,
    output rd_req_valid_i, rd_addr_i, rd_ready_i,
    input  wr_ready_o, rd_req_ready_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i,
    input  rd_req_valid_i, rd_addr_i, rd_ready_i,
    output wr_ready_o, rd_req_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/sram_wide_rd.sv
// Single-port SRAM, narrow writes, RATIO-lane packed reads over RATIO cycles.
// Optional byte-strobe writes are enabled by defining SRAM_WSTRB_EN.
module sram_wide_rd #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_ENTRIES    = 1024,
  parameter int DATA_WIDTH_O = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sram_wide_rd_if.slave bus,
  output logic          busy_o
);
  localparam int RATIO = DATA_WIDTH_O / DATA_WIDTH;
  localparam int AW    = $clog2(N_ENTRIES);
  localparam int CW    = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, READ, OUT} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           base;
  logic [DATA_WIDTH_O-1:0] rd_data;
  logic                    rd_valid;
  logic [DATA_WIDTH-1:0]   mem [N_ENTRIES];

  logic                    wr_ready;
  logic                    rd_req_ready;
  logic                    wr_fire;
  logic                    rd_fire;
  logic [AW-1:0]           lane_addr;
  logic [AW-1:0]           rd_index;
  logic [DATA_WIDTH-1:0]   rd_word;

  // Writes win the single array port in IDLE; READ owns the port outright.
  assign wr_ready     = (state != READ);
  assign rd_req_ready = (state == IDLE) && !bus.wr_valid_i;
  assign wr_fire      = bus.wr_valid_i && wr_ready;
  assign rd_fire      = bus.rd_req_valid_i && rd_req_ready;

  // Lane addresses wrap naturally in AW bits (N_ENTRIES is a power of two).
  assign lane_addr = base + AW'(cnt);
  assign rd_index  = (state == IDLE) ? bus.rd_addr_i : lane_addr;
  assign rd_word   = mem[rd_index];

  assign bus.wr_ready_o     = wr_ready;
  assign bus.rd_req_ready_o = rd_req_ready;
  assign bus.rd_valid_o     = rd_valid;
  assign bus.rd_data_o      = rd_data;

  // NOTE: the array has no reset branch; clearing every entry would cost a
  // write port per word and the contents are undefined until written anyway.
`ifdef SRAM_WSTRB_EN
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (bus.wr_strb_i[b]) mem[bus.wr_addr_i][b*8 +: 8] <= bus.wr_data_i[b*8 +: 8];
      end
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^bus.wr_strb_i;

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[bus.wr_addr_i] <= bus.wr_data_i;
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      base     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_fire) begin
            rd_data[DATA_WIDTH-1:0] <= rd_word;
            base   <= bus.rd_addr_i;
            cnt    <= CW'(1);
            busy_o <= 1'b1;
            if (RATIO > 1) begin
              state <= READ;
            end else begin
              state    <= OUT;
              rd_valid <= 1'b1;
            end
          end
        end
        READ: begin
          rd_data[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= rd_word;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_LANE) begin
            state    <= OUT;
            rd_valid <= 1'b1;
          end
        end
        OUT: begin
          // Held data is only released by the consumer's handshake.
          if (bus.rd_ready_i) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            busy_o   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rd_valid <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_wide_rd.sv
// Scoreboard bench for sram_wide_rd: directed scenarios plus random traffic,
// checked against an array model and a cycle-level handshake model.
module tb_sram_wide_rd;
  localparam int DW    = 32;
  localparam int N     = 1024;
  localparam int DWO   = 64;
  localparam int RATIO = DWO / DW;
  localparam int AW    = $clog2(N);
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  sram_wide_rd_if #(.DATA_WIDTH(DW), .N_ENTRIES(N), .DATA_WIDTH_O(DWO)) bus ();

  sram_wide_rd #(.DATA_WIDTH(DW), .N_ENTRIES(N), .DATA_WIDTH_O(DWO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DWO-1:0] act, input logic [DWO-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the array as plain words, plus the read-channel phase.
  logic [DW-1:0]  ref_mem [N];
  logic [DWO-1:0] exp_q [$];
  bit             active = 1'b0;
  int             acc_cyc = 0;
  bit             just_reset = 1'b1;

  function automatic logic [DWO-1:0] packed_read(input int a);
    logic [DWO-1:0] r;
    for (int k = 0; k < RATIO; k++) r[k*DW +: DW] = ref_mem[(a + k) % N];
    return r;
  endfunction

  task automatic model_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    for (int b = 0; b < NB; b++) begin
      bit en;
`ifdef SRAM_WSTRB_EN
      en = s[b];
`else
      en = 1'b1;
`endif
      if (en) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // Monitor: compares handshake outputs and pops expected packed words.
  bit in_read, out_ph;
  initial begin
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      in_read = active && (cyc < acc_cyc + RATIO);
      out_ph  = active && !in_read;
      check("wr_ready", bus.wr_ready_o, !in_read);
      check("rd_req_ready", bus.rd_req_ready_o, !active && !bus.wr_valid_i);
      check("rd_valid", bus.rd_valid_o, out_ph);
      check("busy", busy, active);
      if (just_reset) begin
        check("rd_data_after_reset", bus.rd_data_o, '0);
        just_reset = 1'b0;
      end
      if (out_ph && exp_q.size() > 0) check("rd_data", bus.rd_data_o, exp_q[0]);
      if (!rst_n) begin
        active = 1'b0;
        exp_q.delete();
        just_reset = 1'b1;
      end else begin
        if (bus.wr_valid_i && !in_read)
          model_write(int'(bus.wr_addr_i), bus.wr_data_i, bus.wr_strb_i);
        if (bus.rd_req_valid_i && !active && !bus.wr_valid_i) begin
          exp_q.push_back(packed_read(int'(bus.rd_addr_i)));
          active  = 1'b1;
          acc_cyc = cyc;
        end else if (out_ph && bus.rd_ready_i) begin
          void'(exp_q.pop_front());
          active = 1'b0;
        end
      end
    end
  end

  // Consumer: random backpressure unless a scenario pins rd_ready_i.
  bit hold_rr = 1'b0;
  bit rr_val  = 1'b1;
  initial begin
    bus.rd_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.rd_ready_i = hold_rr ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    int t = 0;
    bit ok = 1'b0;
    bus.wr_valid_i = 1'b1;
    bus.wr_addr_i  = AW'(a);
    bus.wr_data_i  = d;
    bus.wr_strb_i  = s;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = bus.wr_ready_o;
      step();
      t++;
    end
    bus.wr_valid_i = 1'b0;
    if (!ok) check("write_accept_timeout", ok, 1'b1);
  endtask

  task automatic do_read(input int a);
    int t = 0;
    bit ok = 1'b0;
    bus.rd_req_valid_i = 1'b1;
    bus.rd_addr_i      = AW'(a);
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = bus.rd_req_ready_o;
      step();
      t++;
    end
    bus.rd_req_valid_i = 1'b0;
    if (!ok) check("read_accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_valid(input string name, input logic [DWO-1:0] exp);
    int t = 0;
    @(negedge clk);
    while (!bus.rd_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_valid"}, bus.rd_valid_o, 1'b1);
    check(name, bus.rd_data_o, exp);
    step();
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", busy, 1'b0);
    step();
  endtask

  logic [DWO-1:0] e_bp;
  logic [DW-1:0]  lane0;

  initial begin
    bus.wr_valid_i     = 1'b0;
    bus.wr_addr_i      = '0;
    bus.wr_data_i      = '0;
    bus.wr_strb_i      = '0;
    bus.rd_req_valid_i = 1'b0;
    bus.rd_addr_i      = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a < N; a++) do_write(a, DW'($urandom), '1);

    // Pack two consecutive entries.
    do_write(4, 32'h1111_1111, '1);
    do_write(5, 32'h2222_2222, '1);
    do_read(4);
    wait_valid("pack", 64'h2222_2222_1111_1111);

    // Wrap from the last entry to entry 0.
    do_write(1023, 32'hAAAA_0000, '1);
    do_write(0, 32'h0000_BBBB, '1);
    do_read(1023);
    wait_valid("wrap", 64'h0000_BBBB_AAAA_0000);

    // Write and read request in the same cycle: write wins.
    wait_idle();
    bus.wr_valid_i     = 1'b1;
    bus.wr_addr_i      = AW'(8);
    bus.wr_data_i      = 32'hDEAD_BEEF;
    bus.wr_strb_i      = '1;
    bus.rd_req_valid_i = 1'b1;
    bus.rd_addr_i      = AW'(8);
    @(negedge clk);
    check("contention_rd_req_ready", bus.rd_req_ready_o, 1'b0);
    check("contention_wr_ready", bus.wr_ready_o, 1'b1);
    step();
    bus.wr_valid_i = 1'b0;
    @(negedge clk);
    check("contention_rd_accept_next", bus.rd_req_ready_o, 1'b1);
    step();
    bus.rd_req_valid_i = 1'b0;
    wait_valid("contention", {ref_mem[9], 32'hDEAD_BEEF});

    // Backpressure: data held while a write lands on a lane already read.
    wait_idle();
    hold_rr = 1'b1;
    rr_val  = 1'b0;
    step();
    e_bp = {ref_mem[5], ref_mem[4]};
    do_read(4);
    wait_valid("bp_first", e_bp);
    do_write(4, 32'h0, '1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", bus.rd_valid_o, 1'b1);
      check("bp_data_held", bus.rd_data_o, e_bp);
      step();
    end
    rr_val = 1'b1;
    wait_idle();
    do_read(4);
    wait_valid("bp_reread", {ref_mem[5], 32'h0});

    // Reset while lanes are still being gathered.
    wait_idle();
    do_read(100);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_valid", bus.rd_valid_o, 1'b0);
      check("midrst_busy", busy, 1'b0);
      step();
    end
    do_read(200);
    wait_valid("midrst_new_read", {ref_mem[201], ref_mem[200]});

    // Byte strobes (ignored in the default build).
    wait_idle();
    do_write(3, 32'h1234_5678, '1);
    do_write(3, 32'hFFFF_FFFF, 4'b0101);
`ifdef SRAM_WSTRB_EN
    lane0 = 32'h12FF_56FF;
`else
    lane0 = 32'hFFFF_FFFF;
`endif
    do_read(3);
    wait_valid("strobe", {ref_mem[4], lane0});

    // Random traffic, occasional reset; the monitor does the checking.
    hold_rr = 1'b0;
    repeat (500) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 8) begin
        do_write($urandom_range(0, N - 1), DW'($urandom), NB'($urandom));
      end else if (r < 16) begin
        do_read($urandom_range(0, N - 1));
      end else if (r < 18) begin
        bus.wr_valid_i     = 1'b1;
        bus.wr_addr_i      = AW'($urandom_range(0, N - 1));
        bus.wr_data_i      = DW'($urandom);
        bus.wr_strb_i      = NB'($urandom);
        bus.rd_req_valid_i = 1'b1;
        bus.rd_addr_i      = AW'($urandom_range(0, N - 1));
        step();
        bus.wr_valid_i     = 1'b0;
        bus.rd_req_valid_i = 1'b0;
      end else if (r == 18) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        repeat ($urandom_range(1, 4)) step();
      end
    end

    hold_rr = 1'b1;
    rr_val  = 1'b1;
    wait_idle();
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
